// File: rtl/m_proc_pkg.sv
// Shared m_proc definitions: fetch constants, opcode constants, and the
// fetch entry type passed from the fetch FIFO to execute.
package m_proc_pkg;

    localparam logic [31:0] HALT_IR  = 32'h000f0033;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          IMEM_AW  = 12;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/m_fetch_fifo.sv
// DEPTH-entry FIFO of fetch entries; flush dominates push and pop.
// Ports: clk, rst_n, push/din, pop, flush -> count, head, empty.
module m_fetch_fifo
    import m_proc_pkg::fetch_entry_t;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign count = cnt;
    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);

endmodule

// File: rtl/m_ifetch.sv
// Instruction fetch stage: issues imem reads under a FIFO credit rule,
// buffers {pc, ir}, handles redirect flushes and halt.
// Ports: w_clk, w_rst_n, w_imem_addr/w_imem_data (imem), w_valid/w_ready/
// w_ir/w_pc (to execute), w_redirect/w_redirect_pc, w_halted.
module m_ifetch
    import m_proc_pkg::fetch_entry_t;
#(
    parameter int          DEPTH    = 2,
    parameter int          AW       = m_proc_pkg::IMEM_AW,
    parameter logic [31:0] RESET_PC = m_proc_pkg::RESET_PC,
    parameter logic [31:0] HALT_IR  = m_proc_pkg::HALT_IR
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    output logic [AW-1:0] w_imem_addr,
    input  logic [31:0]   w_imem_data,
    output logic          w_valid,
    input  logic          w_ready,
    output logic [31:0]   w_ir,
    output logic [31:0]   w_pc,
    input  logic          w_redirect,
    input  logic [31:0]   w_redirect_pc,
    output logic          w_halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fpc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;
    logic          r_stop;
    logic          r_halted;

    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  din;
    logic          empty;

    logic          pop;
    logic          push;
    logic          redir;
    logic          halt_seen;
    logic          issue;
    logic [CW:0]   need;
    logic          unused_bits;

    // A redirect after the halt retired is ignored entirely.
    assign redir     = w_redirect & ~r_halted;
    assign pop       = w_valid & w_ready & ~w_redirect;
    assign push      = r_inflight & ~redir;
    assign halt_seen = push & (w_imem_data == HALT_IR);

    // Slots needed after this cycle: occupancy net of the pop plus the
    // return still owed; a new request only fits if this is below DEPTH.
    assign need  = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(r_inflight);
    assign issue = ~r_stop & ~r_halted & ~w_redirect
                 & (need < (CW+1)'(DEPTH));

    assign din = '{pc: r_inflight_pc, ir: w_imem_data};

    m_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (w_clk),
        .rst_n (w_rst_n),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .flush (redir),
        .count (count),
        .head  (head),
        .empty (empty)
    );

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_fpc         <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_stop        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            // A request issued alongside the halt return is wrong-path.
            r_inflight <= issue & ~halt_seen;
            if (issue) begin
                r_inflight_pc <= r_fpc;
            end
            if (redir) begin
                r_fpc <= {w_redirect_pc[31:2], 2'b00};
            end else if (issue) begin
                r_fpc <= r_fpc + 32'd4;
            end
            if (redir) begin
                r_stop <= 1'b0;
            end else if (halt_seen) begin
                r_stop <= 1'b1;
            end
            if (pop && head.ir == HALT_IR) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign w_imem_addr = r_fpc[AW+1:2];
    assign w_valid     = ~empty;
    assign w_ir        = w_valid ? head.ir : '0;
    assign w_pc        = w_valid ? head.pc : '0;
    assign w_halted    = r_halted;
    assign unused_bits = &{1'b0, w_redirect_pc[1:0]};

endmodule
